// File: rtl/mmio_inputs_pkg.sv
// Shared constants for the debounced input register block. The data-memory
// address decoder uses the same offsets and default base address.
package mmio_inputs_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'hffff0004;
  localparam logic [31:0] OFF_LEVEL    = 32'h0000_0000;
  localparam logic [31:0] OFF_EDGE     = 32'h0000_0004;
  localparam logic [31:0] OFF_IEN      = 32'h0000_0008;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LEVEL,
    SEL_EDGE,
    SEL_IEN
  } reg_sel_e;

  // Exact word match only; anything else (including misaligned) is unmapped.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                           input logic [31:0] base);
    if (addr == base + OFF_LEVEL) return SEL_LEVEL;
    if (addr == base + OFF_EDGE)  return SEL_EDGE;
    if (addr == base + OFF_IEN)   return SEL_IEN;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/mmio_inputs_debounce_bit.sv
// One debounced input: 2-flop synchronizer, 3-sample history shifted on tick,
// and the LEVEL flop that only moves when all three samples agree.
module debounce_bit (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [1:0] sync_q, sync_d;
  logic [2:0] hist_q, hist_d;
  logic       level_q, level_d;

  // The level decision looks at the history including the sample being taken,
  // so LEVEL is visible in the cycle right after the tick.
  always_comb begin
    sync_d  = {sync_q[0], din};
    hist_d  = hist_q;
    level_d = level_q;
    rise    = 1'b0;
    if (tick) begin
      hist_d = {hist_q[1:0], sync_q[1]};
      if (hist_d == 3'b111 && !level_q) begin
        level_d = 1'b1;
        rise    = 1'b1;
      end else if (hist_d == 3'b000 && level_q) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/mmio_inputs.sv
// Memory-mapped debounced inputs: LEVEL, sticky W1C EDGE and, when
// MMIO_INPUTS_IRQ_EN is defined, an IEN register and a registered irq output.
module mmio_inputs
  import mmio_inputs_pkg::*;
#(
  parameter int          N_IN     = 16,
  parameter int          DEB_TICK = 50000,
  parameter logic [31:0] BASE     = DEFAULT_BASE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     addr,
  input  logic            we,
  input  logic [31:0]     wd,
  input  logic [N_IN-1:0] entradas,
  output logic [31:0]     rd,
  output logic            hit
`ifdef MMIO_INPUTS_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam int CNT_W = $clog2(DEB_TICK);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       warm_q, warm_d;
  logic [N_IN-1:0]  edge_q, edge_d;
  logic [31:0]      rd_q, rd_d;
  logic             hit_q, hit_d;
  logic             tick;
  logic             armed;
  logic [N_IN-1:0]  level_w;
  logic [N_IN-1:0]  rise_w;
  logic [N_IN-1:0]  clr_mask;
  reg_sel_e         sel;

  for (genvar i = 0; i < N_IN; i++) begin : g_deb
    debounce_bit u_deb (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .din  (entradas[i]),
      .level(level_w[i]),
      .rise (rise_w[i])
    );
  end

  always_comb begin
    sel = decode_addr(addr, BASE);
`ifndef MMIO_INPUTS_IRQ_EN
    if (sel == SEL_IEN) sel = SEL_NONE;
`endif
  end

  // The first three ticks after reset fill the histories; a rise decided on
  // them is just an input that was already high, so it must not mark EDGE.
  always_comb begin
    tick   = (cnt_q == CNT_W'(DEB_TICK - 1));
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    armed  = (warm_q == 2'd3);
    warm_d = (tick && !armed) ? warm_q + 2'd1 : warm_q;
  end

  always_comb begin
    clr_mask = (we && sel == SEL_EDGE) ? wd[N_IN-1:0] : '0;
    edge_d   = (edge_q & ~clr_mask) | (rise_w & {N_IN{armed}});
  end

`ifdef MMIO_INPUTS_IRQ_EN
  logic [N_IN-1:0] ien_q, ien_d;
  logic            irq_q, irq_d;

  always_comb begin
    ien_d = (we && sel == SEL_IEN) ? wd[N_IN-1:0] : ien_q;
    irq_d = |(edge_q & ien_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ien_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_wd;
  assign unused_wd = ^wd;
`endif

  // Reads return the pre-update register values, which also gives the
  // pre-clear EDGE when a read and a W1C land in the same cycle.
  always_comb begin
    rd_d  = '0;
    hit_d = (sel != SEL_NONE);
    case (sel)
      SEL_LEVEL: rd_d[N_IN-1:0] = level_w;
      SEL_EDGE:  rd_d[N_IN-1:0] = edge_q;
`ifdef MMIO_INPUTS_IRQ_EN
      SEL_IEN:   rd_d[N_IN-1:0] = ien_q;
`endif
      default:   rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      warm_q <= '0;
      edge_q <= '0;
      rd_q   <= '0;
      hit_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      warm_q <= warm_d;
      edge_q <= edge_d;
      rd_q   <= rd_d;
      hit_q  <= hit_d;
    end
  end

  assign rd  = rd_q;
  assign hit = hit_q;

endmodule

// File: tb/tb_mmio_inputs.sv
// Self-checking bench for mmio_inputs (DEB_TICK=4, N_IN=16); builds with or
// without MMIO_INPUTS_IRQ_EN and checks rd/hit (and irq) on every cycle.
module tb_mmio_inputs;
  import mmio_inputs_pkg::*;

  localparam int          N_IN     = 16;
  localparam int          DEB_TICK = 4;
  localparam logic [31:0] BASE     = DEFAULT_BASE;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [15:0] entradas;
  logic [31:0] rd;
  logic        hit;
`ifdef MMIO_INPUTS_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  mmio_inputs #(.N_IN(N_IN), .DEB_TICK(DEB_TICK), .BASE(BASE)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .we      (we),
    .wd      (wd),
    .entradas(entradas),
    .rd      (rd),
    .hit     (hit)
`ifdef MMIO_INPUTS_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ein, input logic [31:0] a,
                               input logic w, input logic [31:0] d, input int cycles);
    entradas = ein;
    addr     = a;
    we       = w;
    wd       = d;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Behavioural model: a bit's LEVEL follows the input once the last three
  // tick samples (input seen two clocks earlier) agree; samples are tracked as
  // run lengths of identical values.
  logic [15:0] m_level, m_edge, m_ien;
  logic [31:0] m_rd;
  logic        m_hit, m_irq;
  int          edges_since_rst;
  int          ticks_since_rst;
  logic [15:0] in_q[$];
  logic        run_val[16];
  int          run_len[16];

  always @(posedge clk) begin
    logic [15:0] sample;
    logic [15:0] nedge;
    logic [31:0] nrd;
    logic        nhit;
    logic        tick;
    if (rst) begin
      m_level = '0; m_edge = '0; m_ien = '0; m_rd = '0; m_hit = 1'b0; m_irq = 1'b0;
      edges_since_rst = 0;
      ticks_since_rst = 0;
      in_q.delete();
      for (int i = 0; i < 16; i++) begin
        run_val[i] = 1'b0;
        run_len[i] = 3;
      end
    end else begin
      nrd  = '0;
      nhit = 1'b0;
      if (addr == BASE) begin
        nrd = {16'h0, m_level}; nhit = 1'b1;
      end else if (addr == BASE + 32'd4) begin
        nrd = {16'h0, m_edge}; nhit = 1'b1;
      end
`ifdef MMIO_INPUTS_IRQ_EN
      else if (addr == BASE + 32'd8) begin
        nrd = {16'h0, m_ien}; nhit = 1'b1;
      end
`endif
      m_irq  = |(m_edge & m_ien);
      sample = (in_q.size() >= 2) ? in_q[in_q.size()-2] : 16'h0;
      tick   = (edges_since_rst % DEB_TICK) == DEB_TICK - 1;
      nedge  = m_edge;
      if (we && addr == BASE + 32'd4) nedge = nedge & ~wd[15:0];
      if (tick) begin
        ticks_since_rst++;
        for (int i = 0; i < 16; i++) begin
          if (sample[i] == run_val[i]) begin
            if (run_len[i] < 100) run_len[i]++;
          end else begin
            run_val[i] = sample[i];
            run_len[i] = 1;
          end
          if (run_len[i] >= 3 && run_val[i] != m_level[i]) begin
            m_level[i] = run_val[i];
            if (run_val[i] && ticks_since_rst >= 4) nedge[i] = 1'b1;
          end
        end
      end
`ifdef MMIO_INPUTS_IRQ_EN
      if (we && addr == BASE + 32'd8) m_ien = wd[15:0];
`endif
      m_edge = nedge;
      m_rd   = nrd;
      m_hit  = nhit;
      edges_since_rst++;
      in_q.push_back(entradas);
      if (in_q.size() > 2) void'(in_q.pop_front());
    end
  end

  always @(negedge clk) begin
    checkOutput("model_rd", rd, m_rd);
    checkOutput("model_hit", {31'b0, hit}, {31'b0, m_hit});
`ifdef MMIO_INPUTS_IRQ_EN
    checkOutput("model_irq", {31'b0, irq}, {31'b0, m_irq});
`endif
  end

  initial begin
    logic        found;
    logic [15:0] ein;
    logic [31:0] a;

    rst = 1'b1; we = 1'b0; addr = '0; wd = '0; entradas = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_rd", rd, 32'h0);
    checkOutput("reset_hit", {31'b0, hit}, 32'h0);
    rst = 1'b0;

    // Held-high inputs settle to LEVEL=1 without raising EDGE.
    applyStimulus(16'hFFFF, 32'h0, 1'b0, 32'h0, 16);
    applyStimulus(16'hFFFF, BASE, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("level_after_reset", rd, 32'h0000_FFFF);
    checkOutput("level_hit", {31'b0, hit}, 32'h1);
    applyStimulus(16'hFFFF, BASE + 32'd4, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("edge_after_reset", rd, 32'h0);

    // Bouncing bit 0 never settles high, then a steady high sets EDGE[0].
    applyStimulus(16'hFFFE, 32'h0, 1'b0, 32'h0, 20);
    for (int i = 0; i < 14; i++)
      applyStimulus((i % 2) ? 16'hFFFF : 16'hFFFE, 32'h0, 1'b0, 32'h0, 3);
    applyStimulus(16'hFFFF, BASE, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("level0_while_bouncing", rd, 32'h0000_FFFE);
    applyStimulus(16'hFFFF, 32'h0, 1'b0, 32'h0, 20);
    applyStimulus(16'hFFFF, BASE, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("level0_settled", rd, 32'h0000_FFFF);
    applyStimulus(16'hFFFF, BASE + 32'd4, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("edge0_set", rd, 32'h0000_0001);

    // EDGE=5, then W1C bit 0.
    applyStimulus(16'hFFFB, 32'h0, 1'b0, 32'h0, 20);
    applyStimulus(16'hFFFF, 32'h0, 1'b0, 32'h0, 20);
    applyStimulus(16'hFFFF, BASE + 32'd4, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("edge_0005", rd, 32'h0000_0005);
    applyStimulus(16'hFFFF, BASE + 32'd4, 1'b1, 32'h0000_0001, 1);
    @(negedge clk);
    checkOutput("edge_read_preclear", rd, 32'h0000_0005);
    applyStimulus(16'hFFFF, BASE + 32'd4, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("edge_after_w1c", rd, 32'h0000_0004);

    // Keep clearing bit 2 while it rises: the set must win.
    applyStimulus(16'hFFFF, BASE + 32'd4, 1'b1, 32'hFFFF_FFFF, 1);
    applyStimulus(16'hFFFB, 32'h0, 1'b0, 32'h0, 20);
    entradas = 16'hFFFF; addr = BASE + 32'd4; we = 1'b1; wd = 32'h4;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      found = m_level[2];
    end
    we = 1'b0; addr = 32'h0; wd = 32'h0;
    checkOutput("rise2_seen", {31'b0, found}, 32'h1);
    applyStimulus(16'hFFFF, BASE + 32'd4, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("set_wins_over_clear", rd, 32'h0000_0004);

    // Unmapped and mapped reads; a store to LEVEL does nothing.
    applyStimulus(16'hFFFF, 32'hffff0010, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("unmapped_rd", rd, 32'h0);
    checkOutput("unmapped_hit", {31'b0, hit}, 32'h0);
    applyStimulus(16'hFFFF, BASE, 1'b1, 32'h0, 1);
    applyStimulus(16'hFFFF, BASE, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("level_read", rd, 32'h0000_FFFF);
    checkOutput("level_read_hit", {31'b0, hit}, 32'h1);
    applyStimulus(16'hFFFF, BASE + 32'd8, 1'b0, 32'h0, 1);
    @(negedge clk);
`ifdef MMIO_INPUTS_IRQ_EN
    checkOutput("ien_hit", {31'b0, hit}, 32'h1);
`else
    checkOutput("ien_unmapped_rd", rd, 32'h0);
    checkOutput("ien_unmapped_hit", {31'b0, hit}, 32'h0);
`endif

`ifdef MMIO_INPUTS_IRQ_EN
    applyStimulus(16'hFFFF, BASE + 32'd8, 1'b1, 32'h0000_0002, 1);
    applyStimulus(16'hFFFF, BASE + 32'd4, 1'b1, 32'hFFFF_FFFF, 1);
    applyStimulus(16'hFFFF, BASE + 32'd8, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("ien_readback", rd, 32'h0000_0002);
    applyStimulus(16'hFFFD, 32'h0, 1'b0, 32'h0, 20);
    entradas = 16'hFFFF;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      found = m_edge[1];
    end
    checkOutput("edge1_seen", {31'b0, found}, 32'h1);
    @(negedge clk);
    checkOutput("irq_lags_edge", {31'b0, irq}, 32'h0);
    applyStimulus(16'hFFFF, 32'h0, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("irq_set", {31'b0, irq}, 32'h1);
    applyStimulus(16'hFFFF, BASE + 32'd4, 1'b1, 32'h0000_0002, 1);
    @(negedge clk);
    checkOutput("irq_during_clear", {31'b0, irq}, 32'h1);
    applyStimulus(16'hFFFF, 32'h0, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
`endif

    // Random traffic with occasional mid-debounce resets.
    ein = 16'hFFFF;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) ein = ein ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) ein = ein ^ 16'($urandom);
      case ($urandom_range(0, 5))
        0: a = BASE;
        1: a = BASE + 32'd4;
        2: a = BASE + 32'd8;
        3: a = BASE + 32'd12;
        4: a = BASE - 32'd4;
        default: a = $urandom;
      endcase
      rst = ($urandom_range(0, 399) == 0);
      applyStimulus(ein, a, ($urandom_range(0, 3) == 0), $urandom & $urandom, 1);
    end
    rst = 1'b0;
    applyStimulus(ein, 32'h0, 1'b0, 32'h0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
